game_clock_ctrl: RTL and testbench

Elapsed-time controller for the Sudoku game clock. It gates a 1 ms tick prescaler and accumulates ticks into milliseconds, seconds and minutes. A start/pause/solved/clear state machine sequences it. The elapsed-time display and the win/score logic read its outputs.

---
 rtl/game_pkg.sv | 14 +
 rtl/ms_tick_prescaler.sv | 42 ++++
 rtl/game_clock_ctrl.sv | 141 ++++++++++++++
 tb/tb_game_clock_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the Sudoku game clock.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        PAUSED,
        DONE
    } clk_state_t;

    localparam int unsigned SEC_PER_MIN           = 60;
    localparam int unsigned DEFAULT_CYCLES_PER_MS = 50000;

endpackage

// File: rtl/ms_tick_prescaler.sv
// Divides clk down to a 1 ms tick; the count is held while disabled so that
// pausing never loses or gains partial-millisecond time.
module ms_tick_prescaler
    import game_pkg::*;
#(
    parameter int unsigned CYCLES_PER_MS = DEFAULT_CYCLES_PER_MS
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sclr,
    output logic tick
);

    localparam int unsigned CntW = $clog2(CYCLES_PER_MS);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wrap;

    assign wrap = (cnt_q == CntW'(CYCLES_PER_MS - 1));
    assign tick = en && !sclr && wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (sclr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_clock_ctrl.sv
// Game elapsed-time controller: start/pause/solved/clear FSM driving a
// ms/seconds/minutes accumulator that saturates at MAX_MIN:59.
module game_clock_ctrl
    import game_pkg::*;
#(
    parameter int unsigned CYCLES_PER_MS = DEFAULT_CYCLES_PER_MS,
    parameter int unsigned MS_PER_SEC    = 1000,
    parameter int unsigned MAX_MIN       = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause_toggle,
    input  logic       solved,
    input  logic       clear,
    output logic [6:0] minutes,
    output logic [5:0] seconds,
    output logic       sec_pulse,
    output logic       running,
    output logic       paused,
    output logic       done,
    output logic       overflow
);

    localparam int unsigned MsW = $clog2(MS_PER_SEC);

    clk_state_t     state_q, state_d;
    logic [MsW-1:0] ms_q, ms_d;
    logic [5:0]     sec_q, sec_d;
    logic [6:0]     min_q, min_d;
    logic           ovf_q, ovf_d;
    logic           pulse_q, pulse_d;
    logic           running_q, paused_q, done_q;

    logic solved_go, start_go, ms_wrap, at_max;
    logic ps_en, ps_sclr, ms_tick;

    assign solved_go = solved && (state_q == RUNNING || state_q == PAUSED);
    assign start_go  = start && (state_q == IDLE || state_q == DONE);
    assign ms_wrap   = (ms_q == MsW'(MS_PER_SEC - 1));
    assign at_max    = (min_q == 7'(MAX_MIN)) && (sec_q == 6'(SEC_PER_MIN - 1));

    // clear/solved suppress the prescaler so a colliding tick is never counted.
    assign ps_en   = (state_q == RUNNING) && !clear && !solved;
    assign ps_sclr = clear || start_go;

    ms_tick_prescaler #(
        .CYCLES_PER_MS(CYCLES_PER_MS)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (ps_en),
        .sclr(ps_sclr),
        .tick(ms_tick)
    );

    always_comb begin
        state_d = state_q;
        ms_d    = ms_q;
        sec_d   = sec_q;
        min_d   = min_q;
        ovf_d   = ovf_q;
        pulse_d = 1'b0;
        if (clear) begin
            state_d = IDLE;
            ms_d    = '0;
            sec_d   = '0;
            min_d   = '0;
            ovf_d   = 1'b0;
        end else if (solved_go) begin
            state_d = DONE;
        end else if (start_go) begin
            state_d = RUNNING;
            ms_d    = '0;
            sec_d   = '0;
            min_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (pause_toggle) begin
                case (state_q)
                    RUNNING: state_d = PAUSED;
                    PAUSED:  state_d = RUNNING;
                    default: state_d = state_q;
                endcase
            end
            if (ms_tick) begin
                if (!ms_wrap) begin
                    ms_d = ms_q + 1'b1;
                end else begin
                    ms_d = '0;
                    if (at_max) begin
                        // Saturate: time frozen, no pulse for the lost second.
                        state_d = DONE;
                        ovf_d   = 1'b1;
                    end else begin
                        pulse_d = 1'b1;
                        if (sec_q == 6'(SEC_PER_MIN - 1)) begin
                            sec_d = '0;
                            min_d = min_q + 7'd1;
                        end else begin
                            sec_d = sec_q + 6'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ms_q      <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            ovf_q     <= 1'b0;
            pulse_q   <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ms_q      <= ms_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            ovf_q     <= ovf_d;
            pulse_q   <= pulse_d;
            running_q <= (state_d == RUNNING);
            paused_q  <= (state_d == PAUSED);
            done_q    <= (state_d == DONE);
        end
    end

    assign minutes   = min_q;
    assign seconds   = sec_q;
    assign sec_pulse = pulse_q;
    assign running   = running_q;
    assign paused    = paused_q;
    assign done      = done_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_game_clock_ctrl.sv
// Directed vector bench for game_clock_ctrl at CYCLES_PER_MS=2, MS_PER_SEC=4, MAX_MIN=1.
module tb_game_clock_ctrl;

    logic       clk;
    logic       rst;
    logic       start, pause_toggle, solved, clear;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic       sec_pulse, running, paused, done, overflow;

    int n_cmp  = 0;
    int n_fail = 0;
    int pulse_cnt = 0;

    game_clock_ctrl #(
        .CYCLES_PER_MS(2),
        .MS_PER_SEC   (4),
        .MAX_MIN      (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pause_toggle(pause_toggle),
        .solved      (solved),
        .clear       (clear),
        .minutes     (minutes),
        .seconds     (seconds),
        .sec_pulse   (sec_pulse),
        .running     (running),
        .paused      (paused),
        .done        (done),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {start, pause, solved, clear} applied for the first of n edges, then idle.
    typedef struct {
        logic [3:0] cmd;
        int         n;
        int         e_min;
        int         e_sec;
        logic [3:0] e_flags;  // {running, paused, done, overflow}
        int         e_pulses;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] cmd, int n, int e_min, int e_sec,
                                logic [3:0] e_flags, int e_pulses);
        vec_t v;
        v.cmd      = cmd;
        v.n        = n;
        v.e_min    = e_min;
        v.e_sec    = e_sec;
        v.e_flags  = e_flags;
        v.e_pulses = e_pulses;
        return v;
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (sec_pulse) pulse_cnt++;
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] status();
        return {15'd0, minutes, seconds, running, paused, done, overflow};
    endfunction

    function automatic logic [31:0] pack(int m, int s, logic [3:0] f);
        logic [6:0] m7;
        logic [5:0] s6;
        m7 = 7'(m);
        s6 = 6'(s);
        return {15'd0, m7, s6, f};
    endfunction

    localparam logic [3:0] CS = 4'b1000, CP = 4'b0100, CV = 4'b0010, CC = 4'b0001;
    localparam logic [3:0] FR = 4'b1000, FP = 4'b0100, FD = 4'b0010, FO = 4'b0001;

    initial begin
        string nm;
        int    base;
        rst = 1'b0;
        {start, pause_toggle, solved, clear} = 4'b0;

        // Basic count
        vecs.push_back(mk(4'b0, 2, 0, 0, 4'b0, 0));
        vecs.push_back(mk(CS, 1, 0, 0, FR, 0));
        vecs.push_back(mk(4'b0, 7, 0, 0, FR, 0));
        vecs.push_back(mk(4'b0, 1, 0, 1, FR, 1));
        vecs.push_back(mk(4'b0, 472, 1, 0, FR, 59));
        vecs.push_back(mk(CC, 1, 0, 0, 4'b0, 0));
        // Pause preservation: pause sampled 3 edges after start
        vecs.push_back(mk(CS, 1, 0, 0, FR, 0));
        vecs.push_back(mk(4'b0, 2, 0, 0, FR, 0));
        vecs.push_back(mk(CP, 101, 0, 0, FP, 0));
        vecs.push_back(mk(CP, 5, 0, 0, FR, 0));
        vecs.push_back(mk(4'b0, 1, 0, 1, FR, 1));
        // Solved freeze at 0:37, then restart
        vecs.push_back(mk(4'b0, 288, 0, 37, FR, 36));
        vecs.push_back(mk(CV, 200, 0, 37, FD, 0));
        vecs.push_back(mk(CS, 1, 0, 0, FR, 0));
        // Saturation at 1:59 -> 2:00
        vecs.push_back(mk(4'b0, 952, 1, 59, FR, 119));
        vecs.push_back(mk(4'b0, 7, 1, 59, FR, 0));
        vecs.push_back(mk(4'b0, 1, 1, 59, FD | FO, 0));
        vecs.push_back(mk(CP, 5, 1, 59, FD | FO, 0));
        // start from DONE clears overflow; clear on a seconds-increment edge
        vecs.push_back(mk(CS, 1, 0, 0, FR, 0));
        vecs.push_back(mk(4'b0, 7, 0, 0, FR, 0));
        vecs.push_back(mk(CC | CV, 1, 0, 0, 4'b0, 0));
        // solved on a seconds-increment edge freezes pre-increment time
        vecs.push_back(mk(CS, 1, 0, 0, FR, 0));
        vecs.push_back(mk(4'b0, 7, 0, 0, FR, 0));
        vecs.push_back(mk(CV, 20, 0, 0, FD, 0));
        // start + pause_toggle together from IDLE
        vecs.push_back(mk(CC, 1, 0, 0, 4'b0, 0));
        vecs.push_back(mk(CS | CP, 1, 0, 0, FR, 0));
        vecs.push_back(mk(4'b0, 560, 1, 10, FR, 70));

        // Reset held
        step(3);
        check("reset_state", status(), pack(0, 0, 4'b0));
        check("reset_pulse", {31'd0, sec_pulse}, 32'd0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            base = pulse_cnt;
            {start, pause_toggle, solved, clear} = vecs[i].cmd;
            step(1);
            {start, pause_toggle, solved, clear} = 4'b0;
            if (vecs[i].n > 1) step(vecs[i].n - 1);
            nm = $sformatf("vec%0d_status", i);
            check(nm, status(), pack(vecs[i].e_min, vecs[i].e_sec, vecs[i].e_flags));
            nm = $sformatf("vec%0d_pulses", i);
            check(nm, 32'(pulse_cnt - base), 32'(vecs[i].e_pulses));
        end

        // Async reset between edges while running at 1:10
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_status", status(), pack(0, 0, 4'b0));
        check("async_reset_pulse", {31'd0, sec_pulse}, 32'd0);
        #3;
        step(2);
        rst = 1'b1;
        step(3);
        check("post_reset_idle", status(), pack(0, 0, 4'b0));

        // sec_pulse is high for exactly one cycle
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(7);
        check("pulse_before", {25'd0, seconds, sec_pulse}, {25'd0, 6'd0, 1'b0});
        step(1);
        check("pulse_at", {25'd0, seconds, sec_pulse}, {25'd0, 6'd1, 1'b1});
        step(1);
        check("pulse_after", {25'd0, seconds, sec_pulse}, {25'd0, 6'd1, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
